// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: ALU mode codes, FSM states and mode decode.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ZMXY = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b1100;
  localparam logic [3:0] ALU_RSVD = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // alumode[3:2]: 00 arithmetic, 01/11 logic unit, 10 unsupported
  function automatic logic is_arith(input logic [3:0] mode);
    return mode[3:2] == 2'b00;
  endfunction

  function automatic logic is_invalid(input logic [3:0] mode);
    return mode[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req[idx]) begin
        gnt_any     = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_idx     = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between NREQ requesters, with input
// register staging and a registered (PREG) result returned on a valid/ready channel.
module alu_sched import alu_pkg::*; #(
  parameter int WIDTH = 48,
  parameter int NREQ  = 2,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ*WIDTH-1:0] req_z,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ*4-1:0]     req_alumode,
  input  logic [NREQ-1:0]       req_opmode3,
  output logic [WIDTH-1:0]      alu_x,
  output logic [WIDTH-1:0]      alu_y,
  output logic [WIDTH-1:0]      alu_z,
  output logic                  alu_cin,
  output logic                  alu_multsignin,
  output logic [3:0]            alu_alumode,
  output logic                  alu_opmode3,
  input  logic [WIDTH-1:0]      alu_p,
  input  logic                  alu_carryout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_p,
  output logic                  rsp_carry,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic             cin;
    logic [3:0]       alumode;
    logic             opmode3;
  } op_t;

  state_t          state, nxt;
  logic [IDW-1:0]  rr_ptr, id_q;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            take;
  op_t [NREQ-1:0]  ops;
  op_t             sel;

  assign alu_multsignin = 1'b0;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ops[i] = '{x:       req_x[i*WIDTH +: WIDTH],
                      y:       req_y[i*WIDTH +: WIDTH],
                      z:       req_z[i*WIDTH +: WIDTH],
                      cin:     req_cin[i],
                      alumode: req_alumode[i*4 +: 4],
                      opmode3: req_opmode3[i]};
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // one-hot mux avoids indexing the op array with an over-wide id
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) sel = ops[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // rst_n gates ready so nothing is offered while reset is asserted
  always_comb begin
    nxt       = state;
    req_ready = '0;
    busy      = 1'b1;
    take      = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = (rst_n && gnt_any) ? gnt : '0;
        take      = |req_ready;
        if (take) nxt = S_ISSUE;
      end
      S_ISSUE:   nxt = S_CAPTURE;
      S_CAPTURE: nxt = S_RESP;
      S_RESP:    if (rsp_ready) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      id_q        <= '0;
      alu_x       <= '0;
      alu_y       <= '0;
      alu_z       <= '0;
      alu_cin     <= 1'b0;
      alu_alumode <= '0;
      alu_opmode3 <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_p       <= '0;
      rsp_carry   <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      if (take) begin
        alu_x       <= sel.x;
        alu_y       <= sel.y;
        alu_z       <= sel.z;
        alu_cin     <= sel.cin;
        alu_alumode <= sel.alumode;
        alu_opmode3 <= sel.opmode3;
        id_q        <= gnt_idx;
        rr_ptr      <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      end
      if (state == S_CAPTURE) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_err   <= is_invalid(alu_alumode);
        rsp_carry <= is_arith(alu_alumode) & alu_carryout;
        rsp_p     <= is_invalid(alu_alumode) ? '0 : alu_p;
      end
      if (state == S_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural ALU model closing the loop.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int W = 48, N = 2, IW = 2;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [N*W-1:0]  req_x = '0, req_y = '0, req_z = '0;
  logic [N-1:0]    req_cin = '0, req_opmode3 = '0;
  logic [N*4-1:0]  req_alumode = '0;
  logic [W-1:0]    alu_x, alu_y, alu_z, alu_p;
  logic            alu_cin, alu_multsignin, alu_opmode3, alu_carryout;
  logic [3:0]      alu_alumode;
  logic            rsp_valid, rsp_ready = 1'b1, rsp_carry, rsp_err, busy;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_p;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_sched #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .req_cin(req_cin), .req_alumode(req_alumode), .req_opmode3(req_opmode3),
    .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z), .alu_cin(alu_cin),
    .alu_multsignin(alu_multsignin), .alu_alumode(alu_alumode), .alu_opmode3(alu_opmode3),
    .alu_p(alu_p), .alu_carryout(alu_carryout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_p(rsp_p), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
  );

  // logic/reserved modes drive carryout high so the scheduler's masking is visible
  logic [W:0] s;
  always_comb begin
    s = '0;
    case (alu_alumode)
      ALU_ADD:  s = {1'b0, alu_x} + {1'b0, alu_y} + {1'b0, alu_z} + (W+1)'(alu_cin);
      ALU_ZMXY: s = {1'b0, alu_z} - ({1'b0, alu_x} + {1'b0, alu_y} + (W+1)'(alu_cin));
      ALU_XOR:  s = {1'b1, alu_x ^ alu_z};
      ALU_AND:  s = {1'b1, alu_opmode3 ? (alu_x | alu_z) : (alu_x & alu_z)};
      default:  s = {1'b1, alu_x ^ alu_y ^ 48'h1};
    endcase
  end
  assign alu_p        = s[W-1:0];
  assign alu_carryout = s[W];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] x, y, z,
                          input logic cin, input logic [3:0] mode, input logic op3);
    req_x[i*W +: W]       = x;
    req_y[i*W +: W]       = y;
    req_z[i*W +: W]       = z;
    req_cin[i]            = cin;
    req_alumode[i*4 +: 4] = mode;
    req_opmode3[i]        = op3;
  endtask

  // waits for rsp_valid; lat counts negedges after the handshake edge
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      chk("busy_rdy", {62'd0, busy, |req_ready}, 64'h2);
    end
  endtask

  task automatic run_op(input int i, input logic [W-1:0] x, y, z, input logic cin,
                        input logic [3:0] mode, input logic op3,
                        input logic [W-1:0] ep, input logic ec, input logic ee);
    int lat;
    @(negedge clk);
    set_slot(i, x, y, z, cin, mode, op3);
    req_valid = N'(1) << i;
    #1 chk("grant", req_ready, N'(1) << i);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(lat);
    chk("latency", lat, 3);
    chk("rsp_p", rsp_p, ep);
    chk("rsp_carry", rsp_carry, ec);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_id", rsp_id, i);
    @(posedge clk);
    #1 chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    int lat, nrsp, cyc;
    int ids[$];
    logic [W-1:0] held_p;

    #12;
    chk("rst_rsp", {rsp_valid, rsp_carry, rsp_err, busy}, 0);
    chk("rst_alu", {alu_x[15:0], alu_alumode, alu_cin, alu_opmode3, alu_multsignin}, 0);
    chk("rst_rdy", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op(0, 48'd5, 48'd3, 48'd2, 1'b1, ALU_ADD, 1'b0, 48'd11, 1'b0, 1'b0);
    chk("alu_hold", alu_x, 48'd5);
    run_op(0, 48'hFFFF_FFFF_FFFF, 48'd1, 48'd0, 1'b0, ALU_ADD, 1'b0, 48'd0, 1'b1, 1'b0);
    run_op(0, 48'hFFFF_FFFF_FFFF, 48'd1, 48'd0, 1'b0, ALU_AND, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op(0, 48'hFFFF_FFFF_FFFF, 48'd1, 48'd0, 1'b0, ALU_RSVD, 1'b0, 48'd0, 1'b0, 1'b1);
    run_op(1, 48'd5, 48'd0, 48'd3, 1'b0, ALU_ZMXY, 1'b0, 48'hFFFF_FFFF_FFFE, 1'b1, 1'b0);

    // round-robin with both requesters continuously valid; pointer is at 0 here
    @(negedge clk);
    set_slot(0, 48'd1, 48'd0, 48'd0, 1'b0, ALU_ADD, 1'b0);
    set_slot(1, 48'd2, 48'd0, 48'd0, 1'b0, ALU_ADD, 1'b0);
    req_valid = 2'b11;
    nrsp = 0;
    cyc  = 0;
    while (nrsp < 4 && cyc < 40) begin
      #1 chk("rr_idle_only", (|req_ready) & busy, 0);
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id));
        chk("rr_p", rsp_p, rsp_id == 0 ? 48'd1 : 48'd2);
        nrsp++;
        if (nrsp == 4) req_valid = '0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rr_count", nrsp, 4);
    for (int k = 0; k < 4; k++)
      chk("rr_id", (k < ids.size()) ? ids[k] : 99, k % 2);

    // backpressure: hold the response 5 cycles while requester 1 waits
    @(negedge clk);
    rsp_ready = 1'b0;
    set_slot(0, 48'd7, 48'd0, 48'd0, 1'b0, ALU_ADD, 1'b0);
    set_slot(1, 48'd20, 48'd1, 48'd0, 1'b0, ALU_ADD, 1'b0);
    req_valid = 2'b11;
    #1 chk("bp_grant", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid = 2'b10;
    wait_rsp(lat);
    chk("bp_latency", lat, 3);
    held_p = rsp_p;
    chk("bp_p", held_p, 48'd7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, |req_ready}, {1'b1, 2'd0, 1'b0});
      chk("bp_p_hold", rsp_p, held_p);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 chk("bp_same_cyc", req_ready, 0);
    @(negedge clk);
    chk("bp_next_grant", {rsp_valid, req_ready}, {1'b0, 2'b10});
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(lat);
    chk("bp2_latency", lat, 3);
    chk("bp2_p_id", {rsp_p, rsp_id}, {48'd21, 2'd1});
    @(posedge clk);

    // reset while the op is in ISSUE; pointer is 1 before reset
    @(negedge clk);
    set_slot(0, 48'd9, 48'd0, 48'd0, 1'b0, ALU_ADD, 1'b0);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b11;
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_rsp", {rsp_valid, rsp_carry, rsp_err, busy, rsp_id}, 0);
    chk("rst_async_p", rsp_p, 0);
    chk("rst_async_alu", alu_x, 0);
    chk("rst_async_rdy", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_ptr0", req_ready, 2'b01);
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale", {rsp_valid, busy}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Round-robin scheduler that shares one combinational ALU instance (x/y/z/cin/alumode/opmode3 in; p/carryout out) between NREQ requesters.
- Accepts one operation at a time over a valid/ready handshake and registers the operands into ALU input registers.
- Captures the ALU result in a P register and returns it with the requester ID over a valid/ready response channel.
- Sits between the slice's operand sources and the ALU; it performs the input-register and output-register (PREG) staging.

Parameters:
- WIDTH, 48, datapath width of x/y/z/p.
- NREQ, 2, number of requesters (2..4).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_x  in  NREQ*WIDTH  X operands, requester i at bits [i*WIDTH +: WIDTH].
- req_y  in  NREQ*WIDTH  Y operands, same packing.
- req_z  in  NREQ*WIDTH  Z operands, same packing.
- req_cin  in  NREQ  carry-in per requester.
- req_alumode  in  NREQ*4  ALU mode per requester.
- req_opmode3  in  NREQ  logic-unit select per requester.
- alu_x, alu_y, alu_z  out  WIDTH each  registered operands to the ALU.
- alu_cin  out  1  registered carry-in.
- alu_multsignin  out  1  tied 0.
- alu_alumode  out  4  registered mode.
- alu_opmode3  out  1  registered opmode bit 3.
- alu_p  in  WIDTH  ALU result.
- alu_carryout  in  1  ALU carry out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that issued the op.
- rsp_p  out  WIDTH  registered result.
- rsp_carry  out  1  registered carry; forced 0 for logic modes.
- rsp_err  out  1  set when alumode was 1000..1011 (unsupported).
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr pointer=0, all alu_* outputs=0, rsp_* outputs=0, busy=0, req_ready=0. Mid-operation reset aborts the op and does not produce a response.
- FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE: grant goes to the first requester with valid high, searching from the rr pointer upward and wrapping modulo NREQ. The grantee's req_ready is asserted combinationally in the same cycle. On the handshake, its operands are latched into the alu_* registers, its ID into an id register, and the FSM goes to ISSUE. The rr pointer becomes (grant+1) mod NREQ.
- req_ready is 0 in every state except IDLE, so there is a single outstanding op and no pipelining.
- ISSUE: one cycle for ALU settling; the FSM goes to CAPTURE.
- CAPTURE: latch rsp_p<=alu_p and rsp_carry<=(alumode[3:2]==00 ? alu_carryout : 0). Set rsp_err<=(alumode[3:2]==10) and, when rsp_err is set, force rsp_p<=0. Set rsp_valid<=1 and go to RESP.
- RESP: hold all rsp_* stable while rsp_valid & !rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE. A new grant is possible on the next cycle, never in the same cycle.
- Latency: handshake at cycle T gives rsp_valid at T+3 (registered). Minimum issue interval is 4 cycles with rsp_ready held high.
- alu_* registers hold their value after an op; they are not cleared.
- If no requester is valid in IDLE, the FSM stays in IDLE and the rr pointer is unchanged.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...
- Requesters must hold their operands stable while valid and not yet accepted. The block does not check this.

Decomposition:
- Shared package alu_pkg holds:
  - ALUMODE localparams (ADD=4'b0000, ZMXY=4'b0011, XOR=4'b0100, AND=4'b1100, ...);
  - the FSM state enum (2-bit);
  - an is_arith/is_invalid mode-decode function.
- One sub-module, rr_arbiter: inputs req[NREQ] and ptr; outputs gnt one-hot plus a gnt index. It is purely combinational.

Test Plan:
- Single ADD: req0 with x=5, y=3, z=2, cin=1, alumode=0000, rsp_ready=1 -> rsp_valid at T+3, rsp_p=11, rsp_carry=0, rsp_id=0, rsp_err=0.
- Carry: WIDTH=48, x=48'hFFFF_FFFF_FFFF, y=1, z=0, cin=0, mode 0000 -> rsp_p=0, rsp_carry=1. Same operands with mode 1100 and opmode3=1 -> rsp_p=48'hFFFF_FFFF_FFFF, rsp_carry=0.
- Round-robin: req0 and req1 both held valid for 4 ops -> rsp_id sequence 0,1,0,1; req_ready is never asserted outside IDLE.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_p/rsp_id stay stable, req_ready stays 0, no second op is granted until one cycle after rsp_ready=1.
- Invalid mode: alumode=1000 -> rsp_err=1, rsp_p=0, rsp_carry=0.
- Reset mid-op: rst_n pulled low in ISSUE -> all outputs are 0 immediately (async); after release, state=IDLE, no stale rsp_valid, and the next grant starts from requester 0.
